// File: rtl/qtree_mm_arbiter.sv
// Round-robin arbiter that merges table-write requesters onto the single qtree
// control port, with a built-in clear sequence that zeroes the whole table.
module qtree_mm_arbiter #(
   parameter int REQ_CNT         = 2,
   parameter int MM_ADDR_WIDTH   = 16,
   parameter int MM_DATA_WIDTH   = 32,
   parameter int CLEAR_LAST_ADDR = 2**MM_ADDR_WIDTH-1
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic [REQ_CNT*MM_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [REQ_CNT*MM_DATA_WIDTH-1:0] req_data_i,
   input  logic [REQ_CNT-1:0]               req_valid_i,
   output logic [REQ_CNT-1:0]               req_ready_o,
   input  logic                             clear_start_i,
   output logic                             busy_o,
   output logic [MM_ADDR_WIDTH-1:0]         mm_ctrl_addr_o,
   output logic [MM_DATA_WIDTH-1:0]         mm_ctrl_data_o,
   output logic                             mm_ctrl_write_o
);

   localparam int GW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam logic [MM_ADDR_WIDTH-1:0] LAST_A = MM_ADDR_WIDTH'(CLEAR_LAST_ADDR);
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   logic [0:0]               state_q, state_d;
   logic [MM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [GW-1:0]            last_q, last_d;
   logic [MM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [MM_DATA_WIDTH-1:0] data_q, data_d;
   logic                     wr_q, wr_d;

   logic [2*REQ_CNT-1:0]     dbl;
   logic [REQ_CNT-1:0]       rot, gnt_oh;
   logic                     found;
   logic [GW-1:0]            gnt_idx;
   logic [MM_ADDR_WIDTH-1:0] addr_sel;
   logic [MM_DATA_WIDTH-1:0] data_sel;

   // Rotate valids so bit 0 is the requester right after last_grant, then take the lowest set bit.
   always_comb begin
      int sel;
      dbl     = {req_valid_i, req_valid_i};
      rot     = REQ_CNT'(dbl >> ({1'b0, last_q} + 1'b1));
      found   = 1'b0;
      gnt_idx = last_q;
      sel     = 0;
      for (int k = 0; k < REQ_CNT; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sel   = int'(last_q) + 1 + k;
            if (sel >= REQ_CNT) sel = sel - REQ_CNT;
            gnt_idx = GW'(sel);
         end
      end
   end

   assign gnt_oh      = found ? (REQ_CNT'(1) << gnt_idx) : '0;
   assign req_ready_o = (state_q == RUN && !clear_start_i) ? gnt_oh : '0;
   assign busy_o      = (state_q == CLEAR);

   always_comb begin
      addr_sel = '0;
      data_sel = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         if (gnt_oh[i]) begin
            addr_sel = req_addr_i[i*MM_ADDR_WIDTH +: MM_ADDR_WIDTH];
            data_sel = req_data_i[i*MM_DATA_WIDTH +: MM_DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (state_q == CLEAR) begin
         wr_d   = 1'b1;
         addr_d = cnt_q;
         data_d = '0;
         // Stop on the last address instead of incrementing, so a full-range clear never wraps.
         if (cnt_q == LAST_A) begin
            state_d = RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (clear_start_i) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end else if (found) begin
         wr_d   = 1'b1;
         addr_d = addr_sel;
         data_d = data_sel;
         last_d = gnt_idx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         last_q  <= GW'(REQ_CNT-1);
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign mm_ctrl_write_o = wr_q;
   assign mm_ctrl_addr_o  = addr_q;
   assign mm_ctrl_data_o  = data_q;

endmodule

// File: tb/tb_qtree_mm_arbiter.sv
// Randomized bench for qtree_mm_arbiter against a cycle-level behavioural model.
module tb_qtree_mm_arbiter;
   localparam int N = 2, AW = 16, DW = 32, LAST = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_valid, req_ready;
   logic            clear_start, busy;
   logic [AW-1:0]   mm_addr;
   logic [DW-1:0]   mm_data;
   logic            mm_write;

   always #5 clk = ~clk;

   qtree_mm_arbiter #(.REQ_CNT(N), .MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW),
                      .CLEAR_LAST_ADDR(LAST)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_addr_i(req_addr), .req_data_i(req_data),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .clear_start_i(clear_start),
      .busy_o(busy), .mm_ctrl_addr_o(mm_addr), .mm_ctrl_data_o(mm_data),
      .mm_ctrl_write_o(mm_write));

   int vecs = 0, errs = 0;

   // Model: table is being cleared (next address m_ca) or serving requesters.
   bit            m_clr = 1'b1;
   int            m_ca = 0, m_last = N-1;
   logic          e_w = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_data = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic cycle(input bit rst, input logic [N-1:0] v, input bit cs,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
      logic [N-1:0] e_rdy;
      int g;
      @(negedge clk);
      chk("write", mm_write, e_w);
      chk("addr",  mm_addr,  e_addr);
      chk("data",  mm_data,  e_data);
      chk("busy",  busy,     m_clr);
      rst_n = rst; req_valid = v; clear_start = cs; req_addr = a; req_data = d;
      #1;
      e_rdy = '0;
      if (!rst) begin
         chk("rst_write", mm_write, 0);
         chk("rst_addr",  mm_addr,  0);
         chk("rst_data",  mm_data,  0);
         chk("rst_busy",  busy,     1);
         chk("rst_ready", req_ready, 0);
         m_clr = 1'b1; m_ca = 0; m_last = N-1;
         e_w = 1'b0; e_addr = '0; e_data = '0;
         return;
      end
      if (m_clr) begin
         e_w = 1'b1; e_addr = AW'(m_ca); e_data = '0;
         if (m_ca == LAST) m_clr = 1'b0;
         else m_ca++;
      end else if (cs) begin
         e_w = 1'b0; m_clr = 1'b1; m_ca = 0;
      end else begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && v[(m_last+k)%N]) g = (m_last+k)%N;
         if (g >= 0) begin
            e_rdy[g] = 1'b1; e_w = 1'b1;
            e_addr = a[g*AW +: AW]; e_data = d[g*DW +: DW]; m_last = g;
         end else begin
            e_w = 1'b0;
         end
      end
      chk("ready", req_ready, e_rdy);
   endtask

   initial begin
      logic [N*AW-1:0] ra;
      logic [N*DW-1:0] rd;
      rst_n = 1'b0; req_valid = '0; clear_start = 1'b0; req_addr = '0; req_data = '0;
      cycle(0, 2'b00, 0, '0, '0);
      cycle(0, 2'b00, 0, '0, '0);
      // Clear after release, then idle.
      repeat (6) cycle(1, 2'b00, 0, '0, '0);
      // Both requesters valid: alternation 0,1,0,1.
      repeat (4) cycle(1, 2'b11, 0, {16'h8020, 16'h0010}, {32'h2222_2222, 32'h1111_1111});
      cycle(1, 2'b00, 0, '0, '0);
      // Requester 1 alone.
      cycle(1, 2'b10, 0, {16'h0005, 16'h0000}, {32'hDEAD_BEEF, 32'h0});
      cycle(1, 2'b00, 0, '0, '0);
      cycle(1, 2'b00, 0, '0, '0);
      // Clear start while requester 0 waits; requester 0 wins first RUN cycle.
      cycle(1, 2'b01, 1, {16'h0, 16'h0042}, {32'h0, 32'h0000_0042});
      repeat (5) cycle(1, 2'b01, 0, {16'h0, 16'h0042}, {32'h0, 32'h0000_0042});
      // Clear start pulsed during a clear must not restart it.
      cycle(1, 2'b00, 1, '0, '0);
      cycle(1, 2'b00, 0, '0, '0);
      cycle(1, 2'b00, 1, '0, '0);
      repeat (4) cycle(1, 2'b00, 0, '0, '0);
      // Reset while the clear counter sits at 2.
      cycle(1, 2'b00, 1, '0, '0);
      cycle(1, 2'b00, 0, '0, '0);
      cycle(1, 2'b00, 0, '0, '0);
      cycle(0, 2'b00, 0, '0, '0);
      repeat (7) cycle(1, 2'b00, 0, '0, '0);
      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         rd = {$urandom, $urandom};
         cycle(($urandom_range(0, 49) != 0), N'($urandom), ($urandom_range(0, 15) == 0), ra, rd);
      end
      cycle(1, 2'b00, 0, '0, '0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/qtree_mm_arbiter.md
QTREE_MM_ARBITER -- requirements
Module: qtree_mm_arbiter

Interface
REQ-001 SHALL have parameter REQ_CNT, default 2: number of table-write requesters.
REQ-002 SHALL have parameter MM_ADDR_WIDTH, default 16: width of the qtree control address (MSB 1 = match RAM, 0 = level RAM).
REQ-003 SHALL have parameter MM_DATA_WIDTH, default 32: width of the qtree control data.
REQ-004 SHALL have parameter CLEAR_LAST_ADDR, default 2**MM_ADDR_WIDTH-1: last address written by the clear sequence.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req_addr_i, input, REQ_CNT*MM_ADDR_WIDTH: per-requester write address; requester i occupies bits [i*MM_ADDR_WIDTH +: MM_ADDR_WIDTH].
REQ-008 SHALL have port req_data_i, input, REQ_CNT*MM_DATA_WIDTH: per-requester write data, packed the same way as req_addr_i.
REQ-009 SHALL have port req_valid_i, input, REQ_CNT: per-requester write request.
REQ-010 SHALL have port req_ready_o, output, REQ_CNT: per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-011 SHALL have port clear_start_i, input, 1: single-cycle pulse that starts a table clear.
REQ-012 SHALL have port busy_o, output, 1: 1 while a clear is in progress.
REQ-013 SHALL have port mm_ctrl_addr_o, output, MM_ADDR_WIDTH: drives the qtree control address.
REQ-014 SHALL have port mm_ctrl_data_o, output, MM_DATA_WIDTH: drives the qtree control data.
REQ-015 SHALL have port mm_ctrl_write_o, output, 1: drives the qtree control write strobe.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN, and SHALL enter CLEAR on reset.
REQ-017 In CLEAR, SHALL issue one write per cycle to addresses 0, 1, ..., CLEAR_LAST_ADDR in order, with data 0.
REQ-018 SHALL switch from CLEAR to RUN in the cycle after the write to CLEAR_LAST_ADDR is issued.
REQ-019 In CLEAR, SHALL hold req_ready_o all-zero and busy_o at 1.
REQ-020 SHALL ignore clear_start_i while in CLEAR; the clear SHALL NOT restart.
REQ-021 In RUN, clear_start_i = 1 SHALL force req_ready_o all-zero in that cycle and move the FSM to CLEAR with the address counter at 0 on the next edge.
REQ-022 In RUN with clear_start_i = 0, SHALL grant exactly one valid requester per cycle using round-robin.
- The search starts at (last_grant+1) mod REQ_CNT.
- last_grant resets to REQ_CNT-1, so requester 0 has first priority.
REQ-023 SHALL make req_ready_o combinational from req_valid_i: one-hot on the granted requester, all-zero when no requester is valid.
REQ-024 On each transfer, SHALL register the granted address and data onto mm_ctrl_addr_o and mm_ctrl_data_o and set mm_ctrl_write_o = 1 on the next edge (latency 1 cycle, throughput 1 write per cycle).
REQ-025 Whenever no write is issued in a cycle, SHALL drive mm_ctrl_write_o = 0, with mm_ctrl_addr_o and mm_ctrl_data_o holding their last values.
REQ-026 SHALL update last_grant only on a transfer; a clear SHALL NOT modify last_grant.
REQ-027 SHALL make the clear address counter MM_ADDR_WIDTH bits wide; CLEAR_LAST_ADDR = 2**MM_ADDR_WIDTH-1 SHALL terminate without the counter wrapping.
REQ-028 SHALL never issue more than one mm_ctrl write per cycle and SHALL never issue a requester write while in CLEAR.

Reset
REQ-029 While rst_n_i = 0, SHALL drive asynchronously:
- mm_ctrl_write_o = 0, mm_ctrl_addr_o = 0, mm_ctrl_data_o = 0;
- req_ready_o = 0, busy_o = 1;
- state CLEAR, clear counter 0, last_grant REQ_CNT-1.
REQ-030 If reset asserts mid-clear or mid-write, SHALL abandon the operation; after release, the clear SHALL restart from address 0.

Verification (REQ_CNT=2, CLEAR_LAST_ADDR=3, MM_ADDR_WIDTH=16)
REQ-031 Release reset -> writes to addresses 0, 1, 2, 3 with data 0 on 4 consecutive cycles; busy_o then falls to 0; req_ready_o = 0 throughout the clear.
REQ-032 Requesters 0 and 1 both valid for 4 cycles (addr 0x0010 and 0x8020) -> grant order 0, 1, 0, 1; mm_ctrl_write_o = 1 for 4 consecutive cycles starting 1 cycle after the first grant.
REQ-033 Only requester 1 valid, data 0xDEADBEEF, addr 0x0005 -> next cycle mm_ctrl_addr_o = 0x0005, mm_ctrl_data_o = 0xDEADBEEF, mm_ctrl_write_o = 1 for exactly 1 cycle.
REQ-034 clear_start_i pulsed while requester 0 valid -> req_ready_o = 0 that cycle; the clear writes 0..3; requester 0 is granted in the first RUN cycle.
REQ-035 clear_start_i pulsed again during a clear -> still exactly 4 clear writes.
REQ-036 rst_n_i asserted during clear address 2 -> outputs reset immediately; after release, the clear restarts at address 0.
